// File: rtl/mo_linebuf_sched.sv
// Motion-object line buffer sequencer: swaps the A/B roles every line, scans
// the display buffer for read/clear and streams object pixels into the build buffer.
module mo_linebuf_sched #(
    parameter int unsigned HPIX   = 336,
    parameter int unsigned XW     = 9,
    parameter logic [3:0]  TRANSP = 4'hF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          line_start,
    input  logic          obj_valid,
    output logic          obj_ready,
    input  logic [XW-1:0] obj_x,
    input  logic [2:0]    obj_slices,
    input  logic          obj_hflip,
    output logic          pix_rd,
    input  logic [3:0]    pix_data,
    output logic          padb,
    output logic          wr_en,
    output logic [XW-1:0] wr_addr,
    output logic [3:0]    wr_data,
    output logic          rd_en,
    output logic [XW-1:0] rd_addr,
    output logic          clr_en,
    output logic [XW-1:0] clr_addr,
    output logic          overrun,
    output logic [5:0]    obj_count
);

    localparam int unsigned CW   = XW + 1;
    localparam int unsigned KW   = 6;
    localparam int unsigned CNTW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_dir;
    logic [KW-1:0]   r_left;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_wcol;
    logic            r_wv;
    logic [CNTW-1:0] r_cnt;

    logic [KW-1:0]   w_len_m1;
    logic [CW-1:0]   w_start;
    logic            w_accept;
    logic            w_abort;

    // Object length minus one is (slices-1)*8+7; slices==0 encodes 8 slices.
    assign w_len_m1  = {(obj_slices == 3'd0) ? 3'd7 : 3'(obj_slices - 3'd1), 3'b111};
    assign w_start   = obj_hflip ? CW'(obj_x) + CW'(w_len_m1) : CW'(obj_x);

    // A line boundary always wins over a descriptor offered in the same cycle.
    assign obj_ready = r_ready & ~line_start;
    assign w_accept  = obj_valid & obj_ready;
    assign w_abort   = line_start & ((r_state == S_STREAM) | (r_state == S_DRAIN));

    // Write stage: pen arrives the cycle after pix_rd, column was registered with it.
    assign wr_en   = r_wv && (pix_data != TRANSP) && (r_wcol < CW'(HPIX));
    assign wr_addr = r_wcol[XW-1:0];
    assign wr_data = r_wv ? pix_data : 4'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_dir     <= 1'b0;
            r_left    <= '0;
            r_col     <= '0;
            r_wcol    <= '0;
            r_wv      <= 1'b0;
            r_cnt     <= '0;
            pix_rd    <= 1'b0;
            padb      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            clr_en    <= 1'b0;
            clr_addr  <= '0;
            overrun   <= 1'b0;
            obj_count <= '0;
        end else begin
            overrun <= 1'b0;

            // Display scan; the clear trails the read by one cycle, even across a restart.
            clr_en   <= rd_en;
            clr_addr <= rd_addr;
            if (line_start) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
            end else if (rd_en) begin
                if (rd_addr == XW'(HPIX - 1))
                    rd_en <= 1'b0;
                else
                    rd_addr <= rd_addr + XW'(1);
            end

            r_wv   <= pix_rd & ~line_start;
            r_wcol <= r_col;

            if (line_start) begin
                obj_count <= r_cnt;
                if (r_state != S_IDLE)
                    padb <= ~padb;
            end

            case (r_state)
                S_IDLE: begin
                    if (line_start) begin
                        r_state <= S_ACCEPT;
                        r_ready <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (w_accept) begin
                        r_state <= S_STREAM;
                        r_ready <= 1'b0;
                        pix_rd  <= 1'b1;
                        r_dir   <= obj_hflip;
                        r_col   <= w_start;
                        r_left  <= w_len_m1;
                    end
                end
                S_STREAM: begin
                    if (r_left == '0) begin
                        r_state <= S_DRAIN;
                        pix_rd  <= 1'b0;
                    end else begin
                        r_left <= r_left - KW'(1);
                        r_col  <= r_dir ? r_col - CW'(1) : r_col + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt != {CNTW{1'b1}})
                        r_cnt <= r_cnt + CNTW'(1);
                    r_state <= S_ACCEPT;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase

            // Line boundary mid-object: drop it without counting.
            if (w_abort) begin
                r_state <= S_ACCEPT;
                r_ready <= 1'b1;
                pix_rd  <= 1'b0;
                overrun <= 1'b1;
            end
            if (line_start)
                r_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mo_linebuf_sched.sv
// Self-checking bench for mo_linebuf_sched: directed table, corner sequences
// and random objects against a column/pen list model and a scan model.
module tb_mo_linebuf_sched;

    localparam int HPIX = 336;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic       obj_valid;
    logic       obj_ready;
    logic [8:0] obj_x;
    logic [2:0] obj_slices;
    logic       obj_hflip;
    logic       pix_rd;
    logic [3:0] pix_data;
    logic       padb;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [3:0] wr_data;
    logic       rd_en;
    logic [8:0] rd_addr;
    logic       clr_en;
    logic [8:0] clr_addr;
    logic       overrun;
    logic [5:0] obj_count;

    mo_linebuf_sched dut (
        .clk(clk), .reset(reset), .line_start(line_start),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_x(obj_x),
        .obj_slices(obj_slices), .obj_hflip(obj_hflip),
        .pix_rd(pix_rd), .pix_data(pix_data), .padb(padb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr_en(clr_en), .clr_addr(clr_addr),
        .overrun(overrun), .obj_count(obj_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int act_q[$];
    int exp_q[$];
    int pen_q[$];
    int pix_cnt = 0;
    bit mon_on  = 1'b0;
    int m_pos   = -1;
    int m_clr   = -1;
    bit m_padb  = 1'b0;
    bit m_started = 1'b0;
    bit prev_pix_rd = 1'b0;

    typedef struct {
        int x; int s; int h; int mode;
        int exp_n; int exp_first; int exp_last;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!obj_ready && n < 400) begin
            tick();
            n++;
        end
        if (!obj_ready) chk(name, 0, 1);
    endtask

    // Queue the object's pens and the writes it should produce, then hand it over.
    task automatic send_obj(input int x, input int s, input int h, input int mode);
        int len, pen, col;
        len = 8 * ((s == 0) ? 8 : s);
        for (int k = 0; k < len; k++) begin
            if (mode == 0)      pen = k & 7;
            else if (mode == 1) pen = (k == 3) ? 15 : (k & 7);
            else                pen = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 14));
            pen_q.push_back(pen);
            col = (h != 0) ? x + len - 1 - k : x + k;
            if (pen != 15 && col < HPIX) exp_q.push_back(col * 16 + pen);
        end
        wait_ready("ready_wait");
        obj_x      = 9'(x);
        obj_slices = 3'(s);
        obj_hflip  = (h != 0);
        obj_valid  = 1'b1;
        tick();
        obj_valid  = 1'b0;
    endtask

    task automatic compare_writes();
        int n;
        chk("wr_count", act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("wr_item", act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    // Pixel shifter: a pen for every pix_rd, presented the following cycle.
    always @(posedge clk) begin
        if (pix_rd) begin
            pix_cnt++;
            if (pen_q.size() > 0) pix_data <= 4'(pen_q.pop_front());
            else                  pix_data <= 4'($urandom);
        end else begin
            pix_data <= 4'($urandom);
        end
    end

    // Scan position / role model.
    always @(posedge clk) begin
        if (!reset) begin
            m_pos = -1; m_clr = -1; m_padb = 1'b0; m_started = 1'b0;
        end else begin
            m_clr = m_pos;
            if (line_start) begin
                m_pos = 0;
                if (m_started) m_padb = ~m_padb;
                m_started = 1'b1;
            end else if (m_pos >= 0) begin
                m_pos = (m_pos + 1 < HPIX) ? m_pos + 1 : -1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("rd_en", int'(rd_en), int'(m_pos >= 0));
            if (m_pos >= 0) chk("rd_addr", int'(rd_addr), m_pos);
            chk("clr_en", int'(clr_en), int'(m_clr >= 0));
            if (m_clr >= 0) chk("clr_addr", int'(clr_addr), m_clr);
            chk("padb", int'(padb), int'(m_padb));
            if (wr_en) begin
                chk("wr_latency", int'(prev_pix_rd), 1);
                act_q.push_back(int'(wr_addr) * 16 + int'(wr_data));
            end
            prev_pix_rd = pix_rd;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int low, base, exp_cnt, len, n;
        vecs[0] = '{10,  1, 0, 0, 8,  10,  17};
        vecs[1] = '{10,  1, 1, 0, 8,  17,  10};
        vecs[2] = '{330, 2, 0, 0, 6,  330, 335};
        vecs[3] = '{100, 1, 0, 1, 7,  100, 107};
        vecs[4] = '{500, 0, 1, 0, 0,  -1,  -1};
        vecs[5] = '{328, 1, 1, 0, 8,  335, 328};
        vecs[6] = '{300, 0, 0, 0, 36, 300, 335};

        reset = 1'b0; line_start = 1'b0; obj_valid = 1'b0;
        obj_x = '0; obj_slices = '0; obj_hflip = 1'b0;
        repeat (3) tick();
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_clr_en", int'(clr_en), 0);
        chk("rst_padb", int'(padb), 0);
        chk("rst_obj_ready", int'(obj_ready), 0);
        chk("rst_pix_rd", int'(pix_rd), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_obj_count", int'(obj_count), 0);
        mon_on = 1'b1;
        reset = 1'b1;
        tick();
        chk("idle_ready", int'(obj_ready), 0);

        // First line: no role swap, full scan.
        pulse_line();
        chk("scan1_en", int'(rd_en), 1);
        chk("scan1_addr", int'(rd_addr), 0);
        chk("first_padb", int'(padb), 0);
        chk("accept_ready", int'(obj_ready), 1);
        tick();
        chk("clr2_en", int'(clr_en), 1);
        chk("clr2_addr", int'(clr_addr), 0);
        repeat (334) tick();
        chk("scan336_en", int'(rd_en), 1);
        chk("scan336_addr", int'(rd_addr), 335);
        tick();
        chk("scan337_en", int'(rd_en), 0);
        chk("clr337_addr", int'(clr_addr), 335);

        exp_cnt = 0;
        foreach (vecs[i]) begin
            pulse_line();
            chk("vec_obj_count", int'(obj_count), exp_cnt);
            len  = 8 * ((vecs[i].s == 0) ? 8 : vecs[i].s);
            base = pix_cnt;
            send_obj(vecs[i].x, vecs[i].s, vecs[i].h, vecs[i].mode);
            low = 0;
            while (!obj_ready && low < 200) begin
                low++;
                tick();
            end
            chk("ready_gap", low, len + 1);
            chk("pix_rd_count", pix_cnt - base, len);
            chk("vec_wr_n", act_q.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && act_q.size() > 0) begin
                chk("vec_first_addr", act_q[0] / 16, vecs[i].exp_first);
                chk("vec_last_addr", act_q[act_q.size() - 1] / 16, vecs[i].exp_last);
            end
            compare_writes();
            exp_cnt = 1;
        end

        // Line boundary in the middle of a 64-pixel object.
        pulse_line();
        chk("pre_abort_count", int'(obj_count), 1);
        send_obj(0, 0, 0, 0);
        repeat (18) tick();
        chk("abort_pre_pix_rd", int'(pix_rd), 1);
        pulse_line();
        chk("abort_overrun", int'(overrun), 1);
        chk("abort_pix_rd", int'(pix_rd), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_obj_count", int'(obj_count), 0);
        chk("abort_ready", int'(obj_ready), 1);
        tick();
        chk("abort_overrun_pulse", int'(overrun), 0);
        chk("abort_pix_rd2", int'(pix_rd), 0);
        pen_q.delete(); act_q.delete(); exp_q.delete();

        // Descriptor offered in the line_start cycle is refused.
        line_start = 1'b1; obj_valid = 1'b1; obj_x = 9'd5; obj_slices = 3'd1;
        #1;
        chk("coincide_ready", int'(obj_ready), 0);
        tick();
        line_start = 1'b0; obj_valid = 1'b0;
        #1;
        chk("coincide_pix_rd", int'(pix_rd), 0);
        chk("coincide_ready_back", int'(obj_ready), 1);
        tick();
        chk("coincide_pix_rd2", int'(pix_rd), 0);

        // 70 objects in one line saturate the count.
        pulse_line();
        for (int i = 0; i < 70; i++) send_obj(0, 1, 0, 0);
        wait_ready("sat_done");
        pulse_line();
        chk("sat_obj_count", int'(obj_count), 63);
        compare_writes();

        // Random lines against the model.
        for (int l = 0; l < 6; l++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                send_obj($urandom_range(0, 511), $urandom_range(0, 7), $urandom_range(0, 1), 2);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_ready("rand_done");
            pulse_line();
            chk("rand_obj_count", int'(obj_count), n);
            compare_writes();
            repeat ($urandom_range(0, 20)) tick();
        end

        // Reset during STREAM.
        if (!m_padb) pulse_line();
        send_obj(0, 0, 0, 0);
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk("mrst_padb", int'(padb), 0);
        chk("mrst_pix_rd", int'(pix_rd), 0);
        chk("mrst_ready", int'(obj_ready), 0);
        chk("mrst_wr_en", int'(wr_en), 0);
        chk("mrst_wr_addr", int'(wr_addr), 0);
        chk("mrst_wr_data", int'(wr_data), 0);
        chk("mrst_rd_en", int'(rd_en), 0);
        chk("mrst_rd_addr", int'(rd_addr), 0);
        chk("mrst_clr_en", int'(clr_en), 0);
        chk("mrst_clr_addr", int'(clr_addr), 0);
        chk("mrst_overrun", int'(overrun), 0);
        chk("mrst_obj_count", int'(obj_count), 0);
        reset = 1'b1;
        tick();
        chk("mrst_idle_ready", int'(obj_ready), 0);
        pen_q.delete(); act_q.delete(); exp_q.delete();
        pulse_line();
        chk("post_rst_padb", int'(padb), 0);
        chk("post_rst_ready", int'(obj_ready), 1);
        repeat (5) tick();

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
